// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the seven-segment scan driver: active-low gfedcba
// segment patterns and the scan FSM state type.
package seg_scan_driver_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic {
      SHOW,
      GAP
   } state_e;

endpackage

// File: rtl/seg_scan_driver_hex_to_seg.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module hex_to_seg
   import seg_scan_driver_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (nibble_i)
         4'h0: seg_o = SEG_0;
         4'h1: seg_o = SEG_1;
         4'h2: seg_o = SEG_2;
         4'h3: seg_o = SEG_3;
         4'h4: seg_o = SEG_4;
         4'h5: seg_o = SEG_5;
         4'h6: seg_o = SEG_6;
         4'h7: seg_o = SEG_7;
         4'h8: seg_o = SEG_8;
         4'h9: seg_o = SEG_9;
         4'hA: seg_o = SEG_A;
         4'hB: seg_o = SEG_B;
         4'hC: seg_o = SEG_C;
         4'hD: seg_o = SEG_D;
         4'hE: seg_o = SEG_E;
         4'hF: seg_o = SEG_F;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with frame-synchronous value updates.
// Optional leading-zero blanking is enabled by defining LEAD_ZERO_BLANK_EN.
module seg_scan_driver
   import seg_scan_driver_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned GAP_CYCLES  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
   logic [4*NUM_DIGITS-1:0] shown_q, shown_d;
   logic                    pend_valid_q, pend_valid_d;
   logic [6:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    frame_done_q, frame_done_d;

   logic       slot_end, wrap;
   logic [3:0] nib;
   logic       en_sel, blank, lit;
   logic [6:0] dec_seg;

   hex_to_seg u_hex_to_seg (
      .nibble_i (nib),
      .seg_o    (dec_seg)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      idx_d    = idx_q;
      slot_end = 1'b0;
      case (state_q)
         SHOW: if (cnt_q == SHOW_LAST) begin
            cnt_d = '0;
            if (GAP_CYCLES == 0) slot_end = 1'b1;
            else                 state_d  = GAP;
         end
         GAP: if (cnt_q == GAP_LAST) begin
            cnt_d    = '0;
            state_d  = SHOW;
            slot_end = 1'b1;
         end
         default: state_d = SHOW;
      endcase
      wrap = slot_end && (idx_q == LAST_IDX);
      if (slot_end) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
   end

   // A load coinciding with the frame wrap bypasses pending and lands in shown directly.
   always_comb begin
      pending_d    = pending_q;
      pend_valid_d = pend_valid_q;
      shown_d      = shown_q;
      if (load) begin
         pending_d    = value;
         pend_valid_d = 1'b1;
      end
      if (wrap) begin
         pend_valid_d = 1'b0;
         if (load)              shown_d = value;
         else if (pend_valid_q) shown_d = pending_q;
      end
   end

   always_comb begin
      nib    = '0;
      en_sel = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib    = shown_q[4*i +: 4];
            en_sel = digit_en[i];
         end
      end
   end

`ifdef LEAD_ZERO_BLANK_EN
   logic lz_keep;
   always_comb begin
      lz_keep = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if ((IDX_W'(i) >= idx_q) && (shown_q[4*i +: 4] != 4'h0)) lz_keep = 1'b1;
      end
      blank = (idx_q != '0) && !lz_keep;
   end
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      lit          = (state_q == SHOW) && en_sel && !blank;
      seg_d        = lit ? dec_seg : SEG_BLANK;
      frame_done_d = wrap;
      an_d         = '1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (lit && (idx_q == IDX_W'(i))) an_d[i] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= SHOW;
         idx_q        <= '0;
         cnt_q        <= '0;
         pending_q    <= '0;
         shown_q      <= '0;
         pend_valid_q <= 1'b0;
         seg_q        <= SEG_BLANK;
         an_q         <= '1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         shown_q      <= shown_d;
         pend_valid_q <= pend_valid_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;

endmodule
